// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gating controller.
// Contents:
//   state_e          - controller state encoding (2'd3 is illegal and recovers to ACTIVE)
//   IDLE_CYCLES_DEF  - default idle run length before gating
//   WAKE_CYCLES_DEF  - default enable-to-ready delay after wake-up
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    GATED  = 2'd1,
    WAKE   = 2'd2
  } state_e;

  localparam int unsigned IDLE_CYCLES_DEF = 16;
  localparam int unsigned WAKE_CYCLES_DEF = 2;

endpackage

// File: rtl/clk_gate_ctrl_sat_counter.sv
// sat_counter: parameterised saturating up-counter.
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset, clears the count
//   clr_i  - synchronous clear (takes priority over increment)
//   inc_i  - increment by one; holds at all-ones instead of wrapping
//   cnt_o  - current count (registered)
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: always-on controller producing the enable for the core's
// clock-gating cell. Drops the enable after IDLE_CYCLES consecutive idle
// cycles and restores it on new activity; wake_ready stays low for
// WAKE_CYCLES cycles after the enable returns.
// Ports:
//   clk          - free-running clock (also drives the gating cell)
//   reset        - synchronous active-high reset
//   act          - level-sensitive activity requests (N_SRC bits)
//   force_on     - inhibits gating while high; counts as activity
//   clk_en       - registered enable to the gating cell
//   wake_ready   - gated domain is running and may issue work
//   gated        - high while in GATED
//   gated_cycles - saturating count of cycles spent in GATED
//                  (present only when CLK_GATE_STATS_EN is defined)
// Optional feature macro: CLK_GATE_STATS_EN
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF
`ifdef CLK_GATE_STATS_EN
  ,
  parameter int unsigned STAT_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  act,
  input  logic              force_on,
  output logic              clk_en,
  output logic              wake_ready,
  output logic              gated
`ifdef CLK_GATE_STATS_EN
  ,
  output logic [STAT_W-1:0] gated_cycles
`endif
);

  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  state_e            state_q, state_d;
  logic              clk_en_q, wake_ready_q, gated_q;
  logic              any_act;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAKE_W-1:0] wake_cnt;
  logic              idle_clr, idle_inc;
  logic              wake_clr, wake_inc;

  assign any_act = (|act) | force_on;

  // Counters are held at zero outside their own state, so every entry into
  // ACTIVE or WAKE starts from a clean count.
  always_comb begin
    state_d  = state_q;
    idle_clr = 1'b1;
    idle_inc = 1'b0;
    wake_clr = 1'b1;
    wake_inc = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (!any_act) begin
          if (idle_cnt == IDLE_LAST) begin
            state_d = GATED;
          end else begin
            idle_clr = 1'b0;
            idle_inc = 1'b1;
          end
        end
      end
      GATED: begin
        if (any_act) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_d = ACTIVE;
        end else begin
          wake_clr = 1'b0;
          wake_inc = 1'b1;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register and have no combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACTIVE;
      clk_en_q     <= 1'b1;
      wake_ready_q <= 1'b1;
      gated_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_en_q     <= (state_d != GATED);
      wake_ready_q <= (state_d == ACTIVE);
      gated_q      <= (state_d == GATED);
    end
  end

  sat_counter #(.W(IDLE_W)) u_idle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (idle_clr),
    .inc_i (idle_inc),
    .cnt_o (idle_cnt)
  );

  sat_counter #(.W(WAKE_W)) u_wake_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (wake_clr),
    .inc_i (wake_inc),
    .cnt_o (wake_cnt)
  );

`ifdef CLK_GATE_STATS_EN
  sat_counter #(.W(STAT_W)) u_gated_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .inc_i (state_q == GATED),
    .cnt_o (gated_cycles)
  );
`endif

  assign clk_en     = clk_en_q;
  assign wake_ready = wake_ready_q;
  assign gated      = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl. dut0 uses IDLE_CYCLES=16, WAKE_CYCLES=2;
// dut1 uses IDLE_CYCLES=1, WAKE_CYCLES=1. With CLK_GATE_STATS_EN defined,
// both use STAT_W=4 and gated_cycles is checked as well.
module tb_clk_gate_ctrl;

  localparam int unsigned IDLE0 = 16;
  localparam int unsigned WAKE0 = 2;
`ifdef CLK_GATE_STATS_EN
  localparam int unsigned SW       = 4;
  localparam int unsigned STAT_MAX = (1 << SW) - 1;
`else
  localparam int unsigned STAT_MAX = 0;
`endif
  localparam int unsigned N_ROWS = 29;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] act = 4'h0;
  logic       force_on = 1'b0;
  logic       en0, rdy0, g0, en1, rdy1, g1;
`ifdef CLK_GATE_STATS_EN
  logic [SW-1:0] gc0, gc1;
`endif

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .N_SRC(4), .IDLE_CYCLES(IDLE0), .WAKE_CYCLES(WAKE0)
`ifdef CLK_GATE_STATS_EN
    , .STAT_W(SW)
`endif
  ) dut0 (
    .clk(clk), .reset(reset), .act(act), .force_on(force_on),
    .clk_en(en0), .wake_ready(rdy0), .gated(g0)
`ifdef CLK_GATE_STATS_EN
    , .gated_cycles(gc0)
`endif
  );

  clk_gate_ctrl #(
    .N_SRC(4), .IDLE_CYCLES(1), .WAKE_CYCLES(1)
`ifdef CLK_GATE_STATS_EN
    , .STAT_W(SW)
`endif
  ) dut1 (
    .clk(clk), .reset(reset), .act(act), .force_on(force_on),
    .clk_en(en1), .wake_ready(rdy1), .gated(g1)
`ifdef CLK_GATE_STATS_EN
    , .gated_cycles(gc1)
`endif
  );

  typedef struct {
    int unsigned n;
    logic        rst;
    logic [3:0]  a;
    logic        f;
    logic        en;
    logic        rdy;
    logic        g;
  } vec_t;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        g;
    int unsigned st;
  } exp_t;

  vec_t        tbl [N_ROWS];
  exp_t        exp_q [$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference model of dut0: 0=ACTIVE, 1=GATED, 2=WAKE
  int unsigned m_state = 0;
  int unsigned m_idle  = 0;
  int unsigned m_wake  = 0;
  int unsigned m_stat  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  function automatic void model_step(input logic r, input logic any);
    if (r) begin
      m_state = 0; m_idle = 0; m_wake = 0; m_stat = 0;
    end else begin
      case (m_state)
        0: begin
          if (any) m_idle = 0;
          else if (m_idle + 1 >= IDLE0) begin m_state = 1; m_idle = 0; end
          else m_idle++;
        end
        1: begin
          if (m_stat < STAT_MAX) m_stat++;
          if (any) begin m_state = 2; m_wake = 0; end
        end
        default: begin
          if (m_wake + 1 >= WAKE0) begin m_state = 0; m_idle = 0; end
          else m_wake++;
        end
      endcase
    end
  endfunction

  // Drive one cycle, queue the expectation, then pop and compare after the edge.
  task automatic step(input string tag, input logic r, input logic [3:0] a, input logic f,
                      input bit from_tbl, input exp_t te);
    exp_t e;
    reset = r; act = a; force_on = f;
    model_step(r, (|a) | f);
    if (from_tbl) begin
      e.en = te.en; e.rdy = te.rdy; e.g = te.g;
    end else begin
      e.en = (m_state != 1); e.rdy = (m_state == 0); e.g = (m_state == 1);
    end
    e.st = m_stat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".clk_en"}, 32'(en0), 32'(e.en));
    check({tag, ".wake_ready"}, 32'(rdy0), 32'(e.rdy));
    check({tag, ".gated"}, 32'(g0), 32'(e.g));
`ifdef CLK_GATE_STATS_EN
    check({tag, ".gated_cycles"}, 32'(gc0), e.st);
`endif
  endtask

  task automatic chk1(input string tag, input logic en, input logic rdy, input logic g);
    check({tag, ".dut1.clk_en"}, 32'(en1), 32'(en));
    check({tag, ".dut1.wake_ready"}, 32'(rdy1), 32'(rdy));
    check({tag, ".dut1.gated"}, 32'(g1), 32'(g));
  endtask

  initial begin
    exp_t       none;
    exp_t       te;
    logic       r, f;
    logic [3:0] a;
    none = '{1'b0, 1'b0, 1'b0, 0};

    //         n    rst   act      frc   en    rdy   gated
    tbl[0]  = '{1,   1'b1, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0}; // reset state
    tbl[1]  = '{15,  1'b0, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1,   1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1}; // gates after edge 16
    tbl[3]  = '{5,   1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1,   1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0}; // act[2] pulse wakes
    tbl[5]  = '{1,   1'b0, 4'h0,    1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1,   1'b0, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0}; // ready at N+2
    tbl[7]  = '{15,  1'b0, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1,   1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0}; // activity at threshold wins
    tbl[9]  = '{15,  1'b0, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1,   1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1,   1'b0, 4'h0,    1'b1, 1'b1, 1'b0, 1'b0}; // force_on wakes
    tbl[12] = '{1,   1'b0, 4'h0,    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1,   1'b0, 4'h0,    1'b1, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{100, 1'b0, 4'h0,    1'b1, 1'b1, 1'b1, 1'b0}; // force_on inhibits gating
    tbl[15] = '{15,  1'b0, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1,   1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{3,   1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1,   1'b1, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0}; // reset mid-GATED
    tbl[19] = '{15,  1'b0, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1,   1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1,   1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{1,   1'b0, 4'h0,    1'b0, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{1,   1'b1, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0}; // reset at wake_cnt=1
    tbl[24] = '{15,  1'b0, 4'h0,    1'b0, 1'b1, 1'b1, 1'b0};
    tbl[25] = '{1,   1'b0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1};
    tbl[26] = '{1,   1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[27] = '{1,   1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0}; // held act absorbed
    tbl[28] = '{1,   1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < int'(N_ROWS); i++) begin
      te = '{tbl[i].en, tbl[i].rdy, tbl[i].g, 0};
      for (int c = 0; c < int'(tbl[i].n); c++) begin
        step($sformatf("row%0d.c%0d", i, c), tbl[i].rst, tbl[i].a, tbl[i].f, 1'b1, te);
      end
    end

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      f = ($urandom_range(0, 59) == 0);
      step($sformatf("rnd%0d", i), r, a, f, 1'b0, none);
    end

    // IDLE_CYCLES=1 / WAKE_CYCLES=1 corner on dut1
    step("d1.rst", 1'b1, 4'h0, 1'b0, 1'b0, none);
    chk1("d1.rst", 1'b1, 1'b1, 1'b0);
    step("d1.idle", 1'b0, 4'h0, 1'b0, 1'b0, none);
    chk1("d1.idle", 1'b0, 1'b0, 1'b1);
    step("d1.act", 1'b0, 4'b0001, 1'b0, 1'b0, none);
    chk1("d1.act", 1'b1, 1'b0, 1'b0);
    step("d1.wake", 1'b0, 4'b0001, 1'b0, 1'b0, none);
    chk1("d1.wake", 1'b1, 1'b1, 1'b0);
    step("d1.held", 1'b0, 4'b0001, 1'b0, 1'b0, none);
    chk1("d1.held", 1'b1, 1'b1, 1'b0);
    step("d1.regate", 1'b0, 4'h0, 1'b0, 1'b0, none);
    chk1("d1.regate", 1'b0, 1'b0, 1'b1);

`ifdef CLK_GATE_STATS_EN
    // Statistic saturation: 20 cycles in GATED on a 4-bit counter
    step("st.rst", 1'b1, 4'h0, 1'b0, 1'b0, none);
    check("st.rst.gc", 32'(gc0), 32'd0);
    for (int i = 0; i < 16; i++) step($sformatf("st.idle%0d", i), 1'b0, 4'h0, 1'b0, 1'b0, none);
    check("st.entry.gc", 32'(gc0), 32'd0);
    for (int i = 0; i < 10; i++) step($sformatf("st.g%0d", i), 1'b0, 4'h0, 1'b0, 1'b0, none);
    check("st.mid.gc", 32'(gc0), 32'd10);
    for (int i = 10; i < 20; i++) step($sformatf("st.g%0d", i), 1'b0, 4'h0, 1'b0, 1'b0, none);
    check("st.sat.gc", 32'(gc0), 32'd15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
